// File: rtl/mxu_ctrl_pkg.sv
// rtl/mxu_ctrl_pkg.sv - shared state encoding and defaults for the MXU job controller
package mxu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/mxu_job_controller_counter.sv
// rtl/mxu_job_controller_counter.sv - saturating up-counter used as the RUN timeout counter
module mxu_job_controller_counter #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count up while enabled, hold at all-ones instead of wrapping; clear has priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mxu_job_controller.sv
// rtl/mxu_job_controller.sv - sequences one MXU job: accept, clear MXU, run with timeout, respond
module mxu_job_controller
  import mxu_ctrl_pkg::*;
#(
  parameter int DIM            = 2,
  parameter int BIT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TAG_W          = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [DIM*DIM*BIT_WIDTH-1:0]   req_A,
  input  logic [DIM*DIM*BIT_WIDTH-1:0]   req_B,
  input  logic [TAG_W-1:0]               req_tag,
  output logic                           mxu_rst_n,
  output logic                           mxu_start,
  output logic [DIM*DIM*BIT_WIDTH-1:0]   mxu_A,
  output logic [DIM*DIM*BIT_WIDTH-1:0]   mxu_B,
  input  logic                           mxu_out_valid,
  input  logic [DIM*DIM*2*BIT_WIDTH-1:0] mxu_out,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DIM*DIM*2*BIT_WIDTH-1:0] rsp_C,
  output logic [TAG_W-1:0]               rsp_tag,
  output logic                           rsp_err,
  output logic                           busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state, next_state;
  logic [CNT_W-1:0] cnt;
  logic run_first;
  logic hit_valid;
  logic hit_timeout;
  logic accept;

  // Cycle count within RUN; zero on the first RUN cycle and whenever not running.
  mxu_job_controller_counter #(
    .WIDTH(CNT_W)
  ) u_timeout_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state != ST_RUN),
    .en     (1'b1),
    .count  (cnt)
  );

  assign accept      = (state == ST_IDLE) && req_valid;
  assign run_first   = (state == ST_RUN) && (cnt == '0);
  // The MXU valid level is stale on the first RUN cycle, so it only counts afterwards.
  assign hit_valid   = (state == ST_RUN) && !run_first && mxu_out_valid;
  assign hit_timeout = (state == ST_RUN) && !hit_valid && (cnt == LAST_CNT);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and the handshake/strobe outputs that follow the current state.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    mxu_start  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        next_state = ST_RUN;
      end
      ST_RUN: begin
        mxu_start = run_first;
        if (hit_valid || hit_timeout) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // MXU reset is registered so it is a clean one-cycle low pulse aligned with CLEAR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mxu_rst_n <= 1'b0;
    end else begin
      mxu_rst_n <= (next_state != ST_CLEAR);
    end
  end

  // Operands and tag are latched only at acceptance and held until the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mxu_A   <= '0;
      mxu_B   <= '0;
      rsp_tag <= '0;
    end else if (accept) begin
      mxu_A   <= req_A;
      mxu_B   <= req_B;
      rsp_tag <= req_tag;
    end
  end

  // Result capture on the leaving RUN cycle; a timeout reports a zero matrix with the error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_C   <= '0;
      rsp_err <= 1'b0;
    end else if (hit_valid) begin
      rsp_C   <= mxu_out;
      rsp_err <= 1'b0;
    end else if (hit_timeout) begin
      rsp_C   <= '0;
      rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mxu_job_controller.sv
// tb/tb_mxu_job_controller.sv - directed self-checking bench for mxu_job_controller with a behavioural MXU stub
module tb_mxu_job_controller;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_A;
  logic [15:0] req_B;
  logic [3:0]  req_tag;
  logic        mxu_rst_n;
  logic        mxu_start;
  logic [15:0] mxu_A;
  logic [15:0] mxu_B;
  logic        stub_valid;
  logic [31:0] stub_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_C;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  bit   stub_en;
  logic stub_run;
  int   stub_cnt;

  int   low_cycles = 0;
  int   low_pulses = 0;
  logic prev_rst_n = 1'b1;

  mxu_job_controller #(
    .DIM           (2),
    .BIT_WIDTH     (4),
    .TIMEOUT_CYCLES(16),
    .TAG_W         (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_A        (req_A),
    .req_B        (req_B),
    .req_tag      (req_tag),
    .mxu_rst_n    (mxu_rst_n),
    .mxu_start    (mxu_start),
    .mxu_A        (mxu_A),
    .mxu_B        (mxu_B),
    .mxu_out_valid(stub_valid),
    .mxu_out      (stub_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_C        (rsp_C),
    .rsp_tag      (rsp_tag),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] matmul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] c;
    logic signed [3:0] x, y;
    logic signed [7:0] xs, ys, s;
    c = '0;
    for (int r = 0; r < 2; r++) begin
      for (int col = 0; col < 2; col++) begin
        s = '0;
        for (int k = 0; k < 2; k++) begin
          x  = a[(r*2+k)*4 +: 4];
          y  = b[(k*2+col)*4 +: 4];
          xs = x;
          ys = y;
          s  = s + xs * ys;
        end
        c[(r*2+col)*8 +: 8] = s;
      end
    end
    return c;
  endfunction

  // MXU stand-in: result becomes valid four cycles after the start strobe.
  always @(posedge clk) begin
    if (!mxu_rst_n) begin
      stub_valid <= 1'b0;
      stub_run   <= 1'b0;
      stub_cnt   <= 0;
      stub_out   <= '0;
    end else if (mxu_start && stub_en) begin
      stub_run <= 1'b1;
      stub_cnt <= 0;
    end else if (stub_run) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == 3) begin
        stub_valid <= 1'b1;
        stub_out   <= matmul(mxu_A, mxu_B);
        stub_run   <= 1'b0;
      end
    end
  end

  // Tally MXU reset low cycles and falling edges outside of the global reset.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!mxu_rst_n) low_cycles <= low_cycles + 1;
      if (prev_rst_n && !mxu_rst_n) low_pulses <= low_pulses + 1;
    end
    prev_rst_n <= mxu_rst_n;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                         input logic [31:0] exp_c, input logic exp_err, input int exp_lat,
                         input int hold);
    int k;
    check("idle_req_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_A     = a;
    req_B     = b;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
    req_A     = ~a;
    req_B     = ~b;
    req_tag   = ~tag;
    check("clear_mxu_rst_n", 64'(mxu_rst_n), 64'(0));
    check("clear_req_ready", 64'(req_ready), 64'(0));
    check("clear_busy", 64'(busy), 64'(1));
    check("clear_start", 64'(mxu_start), 64'(0));
    tick();
    check("run_start", 64'(mxu_start), 64'(1));
    check("run_mxu_rst_n", 64'(mxu_rst_n), 64'(1));
    check("held_A", 64'(mxu_A), 64'(a));
    check("held_B", 64'(mxu_B), 64'(b));
    k = 0;
    while (!rsp_valid && k < 100) begin
      tick();
      k++;
      if (k == 1) check("start_one_cycle", 64'(mxu_start), 64'(0));
    end
    check("rsp_seen", 64'(rsp_valid), 64'(1));
    if (exp_lat >= 0) check("rsp_latency", 64'(k), 64'(exp_lat));
    check("rsp_C", 64'(rsp_C), 64'(exp_c));
    check("rsp_tag", 64'(rsp_tag), 64'(tag));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 64'(rsp_valid), 64'(1));
      check("hold_C", 64'(rsp_C), 64'(exp_c));
      check("hold_tag", 64'(rsp_tag), 64'(tag));
      check("hold_req_ready", 64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_hs_valid", 64'(rsp_valid), 64'(0));
    check("post_hs_req_ready", 64'(req_ready), 64'(1));
    check("post_hs_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int cyc0, pul0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_A     = 16'hFFFF;
    req_B     = 16'hFFFF;
    req_tag   = 4'hF;
    rsp_ready = 1'b0;
    stub_en   = 1'b1;
    tick();
    tick();
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mxu_rst_n", 64'(mxu_rst_n), 64'(0));
    check("rst_mxu_start", 64'(mxu_start), 64'(0));
    check("rst_rsp_C", 64'(rsp_C), 64'(0));
    check("rst_rsp_tag", 64'(rsp_tag), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    check("rst_mxu_A", 64'(mxu_A), 64'(0));
    reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_mxu_rst_n", 64'(mxu_rst_n), 64'(1));

    // A=[[1,2],[3,4]], B=I, tag 5
    run_job(16'h4321, 16'h1001, 4'd5, 32'h04030201, 1'b0, 6, 0);
    // A=[[-1,2],[3,-4]], B=[[2,1],[1,2]] -> [[0,3],[2,-5]], response held 20 cycles
    run_job(16'hC32F, 16'h2112, 4'd6, 32'hFB020300, 1'b0, 6, 20);

    // MXU never answers: timeout 16 cycles after start
    stub_en = 1'b0;
    run_job(16'h4321, 16'h1001, 4'd9, 32'h0, 1'b1, 16, 0);
    stub_en = 1'b1;

    // Reset in the middle of RUN discards the job
    req_valid = 1'b1;
    req_A     = 16'h4321;
    req_B     = 16'h1001;
    req_tag   = 4'd3;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_busy", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_req_ready", 64'(req_ready), 64'(1));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_mxu_rst_n", 64'(mxu_rst_n), 64'(0));
    check("mid_rst_mxu_A", 64'(mxu_A), 64'(0));
    check("mid_rst_rsp_tag", 64'(rsp_tag), 64'(0));
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("no_stale_rsp", 64'(rsp_valid), 64'(0));
    check("no_stale_busy", 64'(busy), 64'(0));
    run_job(16'hC32F, 16'h2112, 4'd7, 32'hFB020300, 1'b0, 6, 0);

    // Back-to-back jobs: one MXU reset pulse each, responses in order
    cyc0 = low_cycles;
    pul0 = low_pulses;
    run_job(16'h4321, 16'h1001, 4'd10, 32'h04030201, 1'b0, 6, 0);
    run_job(16'hC32F, 16'h2112, 4'd11, 32'hFB020300, 1'b0, 6, 0);
    tick();
    check("b2b_low_cycles", 64'(low_cycles - cyc0), 64'(2));
    check("b2b_low_pulses", 64'(low_pulses - pul0), 64'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
